arcade_rom_loader: RTL and testbench

Converts the HPS `ioctl` byte download stream into byte-lane writes for the 16-bit game ROM store and per-chip writes for the colour/timing PROMs. Sits between `hps_io` and the game core / `jtgng_prom` instances. Holds the game core in reset until a complete image has been loaded and a settling interval has elapsed. Flags images that overrun the defined regions.

---
 rtl/arcade_loader_pkg.sv | 24 ++
 rtl/arcade_rom_region_dec.sv | 39 +++
 rtl/arcade_rom_loader.sv | 162 ++++++++++++++++
 tb/tb_arcade_rom_loader.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/arcade_loader_pkg.sv
// Purpose : shared types and constants for the arcade ROM loader.
// Latency : n/a (types and constants only).
// Backpressure: n/a.
package arcade_loader_pkg;

  // Loader sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_SETTLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Destination of one downloaded byte.
  typedef enum logic [1:0] {
    RGN_NONE = 2'd0,
    RGN_ROM  = 2'd1,
    RGN_PROM = 2'd2
  } region_e;

  localparam int PROM_BYTES = 256;  // bytes per colour/timing PROM
  localparam int PROM_LW    = 8;    // log2(PROM_BYTES)

endpackage

// File: rtl/arcade_rom_region_dec.sv
// Purpose : decodes an ioctl byte address into ROM / PROM / out-of-range.
// Latency : combinational, zero cycles.
// Backpressure: none; pure function of addr.
// Ports   : addr (byte address) -> region, prom_idx (PROM number),
//           word_addr (ROM word address), lane_hi (1 = high byte lane).
module arcade_rom_region_dec
  import arcade_loader_pkg::*;
#(
  parameter int AW       = 25,
  parameter int PW       = 17,
  parameter int ROM_END  = 'h1C000,
  parameter int PROM_NUM = 8,
  parameter int IW       = (PROM_NUM > 1) ? $clog2(PROM_NUM) : 1
) (
  input  logic [AW-1:0] addr,
  output region_e       region,
  output logic [IW-1:0] prom_idx,
  output logic [PW-1:0] word_addr,
  output logic          lane_hi
);

  localparam logic [AW-1:0] ROM_LIM  = AW'(ROM_END);
  localparam logic [AW-1:0] PROM_LIM = AW'(ROM_END + PROM_BYTES * PROM_NUM);

  always_comb begin
    region = RGN_NONE;
    if (addr < ROM_LIM) begin
      region = RGN_ROM;
    end else if (addr < PROM_LIM) begin
      region = RGN_PROM;
    end
  end

  // Only meaningful when region is RGN_PROM; the caller gates on region.
  assign prom_idx  = IW'((addr - ROM_LIM) >> PROM_LW);
  assign word_addr = addr[PW:1];
  assign lane_hi   = addr[0];

endmodule

// File: rtl/arcade_rom_loader.sv
// Purpose : turns the HPS ioctl byte stream into ROM lane writes and PROM writes,
//           and holds the game core in reset until the image is loaded and settled.
// Latency : one cycle from ioctl_wr to prog_we/prom_we; all outputs registered.
// Backpressure: none; accepts one byte per cycle indefinitely.
// Ports   : clk, rst (sync, active high); downloading/ioctl_addr/ioctl_data/ioctl_wr
//           from hps_io; prog_* to the ROM store; prom_we/prom_addr (data on
//           prog_data) to the PROMs; loader_rst, rom_ready, overflow status.
module arcade_rom_loader
  import arcade_loader_pkg::*;
#(
  parameter int AW       = 25,
  parameter int PW       = 17,
  parameter int ROM_END  = 'h1C000,
  parameter int PROM_NUM = 8,
  parameter int RST_HOLD = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                downloading,
  input  logic [AW-1:0]       ioctl_addr,
  input  logic [7:0]          ioctl_data,
  input  logic                ioctl_wr,
  output logic [PW-1:0]       prog_addr,
  output logic [7:0]          prog_data,
  output logic [1:0]          prog_mask,
  output logic                prog_we,
  output logic [PROM_NUM-1:0] prom_we,
  output logic [7:0]          prom_addr,
  output logic                loader_rst,
  output logic                rom_ready,
  output logic                overflow
);

  localparam int IW = (PROM_NUM > 1) ? $clog2(PROM_NUM) : 1;
  localparam int CW = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;

  state_e        state, state_nx;
  logic [CW-1:0] hold_cnt;

  region_e       rgn;
  logic [IW-1:0] rgn_idx;
  logic [PW-1:0] rgn_waddr;
  logic          rgn_hi;
  logic          wr_acc;

  logic [PW-1:0]       prog_addr_nx;
  logic [7:0]          prog_data_nx;
  logic [1:0]          prog_mask_nx;
  logic                prog_we_nx;
  logic [PROM_NUM-1:0] prom_we_nx;
  logic [7:0]          prom_addr_nx;
  logic                loader_rst_nx;
  logic                rom_ready_nx;
  logic                overflow_nx;

  arcade_rom_region_dec #(
    .AW(AW), .PW(PW), .ROM_END(ROM_END), .PROM_NUM(PROM_NUM), .IW(IW)
  ) u_dec (
    .addr     (ioctl_addr),
    .region   (rgn),
    .prom_idx (rgn_idx),
    .word_addr(rgn_waddr),
    .lane_hi  (rgn_hi)
  );

  // Bytes are only taken while in LOAD; this includes the cycle in which
  // downloading falls, since the state is still LOAD then.
  assign wr_acc = (state == ST_LOAD) && ioctl_wr;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Settle counter: loaded on leaving LOAD, runs down while in SETTLE.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_cnt <= '0;
    end else if (state == ST_LOAD && !downloading) begin
      hold_cnt <= CW'(RST_HOLD - 1);
    end else if (state == ST_SETTLE && hold_cnt != '0) begin
      hold_cnt <= hold_cnt - CW'(1);
    end
  end

  // Next-state logic.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:   if (downloading) state_nx = ST_LOAD;
      ST_LOAD:   if (!downloading) state_nx = ST_SETTLE;
      ST_SETTLE: begin
        if (downloading)          state_nx = ST_LOAD;
        else if (hold_cnt == '0)  state_nx = ST_DONE;
      end
      ST_DONE:   if (downloading) state_nx = ST_LOAD;
      default:   state_nx = ST_IDLE;
    endcase
  end

  // Output logic: next values for the output registers. Status follows the
  // next state so loader_rst/rom_ready change in the same cycle the state does.
  always_comb begin
    prog_addr_nx  = prog_addr;
    prog_data_nx  = prog_data;
    prog_mask_nx  = prog_mask;
    prog_we_nx    = 1'b0;
    prom_we_nx    = '0;
    prom_addr_nx  = prom_addr;
    overflow_nx   = overflow;
    loader_rst_nx = (state_nx != ST_DONE);
    rom_ready_nx  = (state_nx == ST_DONE);

    if (state != ST_LOAD && state_nx == ST_LOAD) begin
      overflow_nx = 1'b0;
    end

    if (wr_acc) begin
      case (rgn)
        RGN_ROM: begin
          prog_addr_nx = rgn_waddr;
          prog_data_nx = ioctl_data;
          prog_mask_nx = rgn_hi ? 2'b01 : 2'b10;
          prog_we_nx   = 1'b1;
        end
        RGN_PROM: begin
          prom_we_nx   = PROM_NUM'(1) << rgn_idx;
          prom_addr_nx = ioctl_addr[7:0];
          prog_data_nx = ioctl_data;
        end
        default: overflow_nx = 1'b1;
      endcase
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      prog_addr  <= '0;
      prog_data  <= '0;
      prog_mask  <= 2'b11;
      prog_we    <= 1'b0;
      prom_we    <= '0;
      prom_addr  <= '0;
      loader_rst <= 1'b1;
      rom_ready  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      prog_addr  <= prog_addr_nx;
      prog_data  <= prog_data_nx;
      prog_mask  <= prog_mask_nx;
      prog_we    <= prog_we_nx;
      prom_we    <= prom_we_nx;
      prom_addr  <= prom_addr_nx;
      loader_rst <= loader_rst_nx;
      rom_ready  <= rom_ready_nx;
      overflow   <= overflow_nx;
    end
  end

endmodule

// File: tb/tb_arcade_rom_loader.sv
// Purpose : directed self-checking bench for arcade_rom_loader (default parameters).
// Latency : inputs driven 1ns after a rising edge, outputs read 1ns after the next.
// Backpressure: n/a.
module tb_arcade_rom_loader;

  localparam logic [24:0] ROM_END = 25'h1C000;

  logic        clk = 1'b0;
  logic        rst;
  logic        downloading;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_data;
  logic        ioctl_wr;
  logic [16:0] prog_addr;
  logic [7:0]  prog_data;
  logic [1:0]  prog_mask;
  logic        prog_we;
  logic [7:0]  prom_we;
  logic [7:0]  prom_addr;
  logic        loader_rst;
  logic        rom_ready;
  logic        overflow;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  arcade_rom_loader dut (
    .clk        (clk),
    .rst        (rst),
    .downloading(downloading),
    .ioctl_addr (ioctl_addr),
    .ioctl_data (ioctl_data),
    .ioctl_wr   (ioctl_wr),
    .prog_addr  (prog_addr),
    .prog_data  (prog_data),
    .prog_mask  (prog_mask),
    .prog_we    (prog_we),
    .prom_we    (prom_we),
    .prom_addr  (prom_addr),
    .loader_rst (loader_rst),
    .rom_ready  (rom_ready),
    .overflow   (overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one byte for a single cycle; outputs for it are readable on return.
  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_data = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; downloading = 1'b0; ioctl_addr = '0; ioctl_data = '0; ioctl_wr = 1'b0;
    tick(); tick();
    rst = 1'b0;
    tick();
    n_chk++; if ({prog_addr, prog_data, prog_mask, prog_we} !== {17'h0, 8'h0, 2'b11, 1'b0}) begin
      n_fail++; $display("FAIL reset_prog got addr=%h data=%h mask=%b we=%b want 0/00/11/0", prog_addr, prog_data, prog_mask, prog_we); end
    n_chk++; if ({prom_we, prom_addr} !== 16'h0) begin
      n_fail++; $display("FAIL reset_prom got we=%b addr=%h want 0/0", prom_we, prom_addr); end
    n_chk++; if ({loader_rst, rom_ready, overflow} !== 3'b100) begin
      n_fail++; $display("FAIL reset_status got rst=%b rdy=%b ovf=%b want 1/0/0", loader_rst, rom_ready, overflow); end
  endtask

  task automatic test_rom_lanes();
    downloading = 1'b1;
    tick();
    wr_byte(25'h0, 8'hAA);
    n_chk++; if ({prog_we, prog_addr, prog_mask, prog_data} !== {1'b1, 17'h0, 2'b10, 8'hAA}) begin
      n_fail++; $display("FAIL rom_lo got we=%b addr=%h mask=%b data=%h want 1/0/10/aa", prog_we, prog_addr, prog_mask, prog_data); end
    wr_byte(25'h1, 8'h55);
    n_chk++; if ({prog_we, prog_addr, prog_mask, prog_data} !== {1'b1, 17'h0, 2'b01, 8'h55}) begin
      n_fail++; $display("FAIL rom_hi got we=%b addr=%h mask=%b data=%h want 1/0/01/55", prog_we, prog_addr, prog_mask, prog_data); end
    tick();
    n_chk++; if ({prog_we, prog_addr, prog_mask, prog_data} !== {1'b0, 17'h0, 2'b01, 8'h55}) begin
      n_fail++; $display("FAIL rom_hold got we=%b addr=%h mask=%b data=%h want 0/0/01/55", prog_we, prog_addr, prog_mask, prog_data); end
  endtask

  task automatic test_prom();
    wr_byte(ROM_END + 25'h205, 8'h3C);
    n_chk++; if ({prom_we, prom_addr, prog_data, prog_we} !== {8'b0000_0100, 8'h05, 8'h3C, 1'b0}) begin
      n_fail++; $display("FAIL prom2 got we=%b addr=%h data=%h pwe=%b want 00000100/05/3c/0", prom_we, prom_addr, prog_data, prog_we); end
    tick();
    n_chk++; if ({prom_we, prom_addr} !== {8'h00, 8'h05}) begin
      n_fail++; $display("FAIL prom_pulse got we=%b addr=%h want 0/05", prom_we, prom_addr); end
  endtask

  task automatic test_region_edges();
    wr_byte(ROM_END - 25'h1, 8'h11);
    n_chk++; if ({prog_we, prog_addr, prog_mask, prom_we} !== {1'b1, 17'hDFFF, 2'b01, 8'h00}) begin
      n_fail++; $display("FAIL rom_last got we=%b addr=%h mask=%b prom=%b want 1/dfff/01/0", prog_we, prog_addr, prog_mask, prom_we); end
    wr_byte(ROM_END + 25'd2047, 8'h22);
    n_chk++; if ({prom_we, prom_addr, prog_we, overflow} !== {8'h80, 8'hFF, 1'b0, 1'b0}) begin
      n_fail++; $display("FAIL prom_last got we=%b addr=%h pwe=%b ovf=%b want 10000000/ff/0/0", prom_we, prom_addr, prog_we, overflow); end
    wr_byte(ROM_END + 25'd2048, 8'h77);
    n_chk++; if ({prog_we, prom_we, overflow, prog_data} !== {1'b0, 8'h00, 1'b1, 8'h22}) begin
      n_fail++; $display("FAIL overrun got pwe=%b prom=%b ovf=%b data=%h want 0/0/1/22", prog_we, prom_we, overflow, prog_data); end
  endtask

  task automatic test_settle();
    // Final byte arrives in the same cycle downloading falls.
    downloading = 1'b0;
    wr_byte(25'h6, 8'hE7);
    n_chk++; if ({prog_we, prog_addr, prog_mask, prog_data} !== {1'b1, 17'h3, 2'b10, 8'hE7}) begin
      n_fail++; $display("FAIL last_byte got we=%b addr=%h mask=%b data=%h want 1/3/10/e7", prog_we, prog_addr, prog_mask, prog_data); end
    n_chk++; if ({loader_rst, rom_ready} !== 2'b10) begin
      n_fail++; $display("FAIL settle_0 got rst=%b rdy=%b want 1/0", loader_rst, rom_ready); end
    for (int c = 1; c < 16; c++) begin
      tick();
      n_chk++; if ({loader_rst, rom_ready} !== 2'b10) begin
        n_fail++; $display("FAIL settle_%0d got rst=%b rdy=%b want 1/0", c, loader_rst, rom_ready); end
    end
    tick();
    n_chk++; if ({loader_rst, rom_ready, overflow} !== 3'b011) begin
      n_fail++; $display("FAIL settle_done got rst=%b rdy=%b ovf=%b want 0/1/1", loader_rst, rom_ready, overflow); end
  endtask

  task automatic test_reload_clears();
    downloading = 1'b1;
    tick();
    n_chk++; if ({loader_rst, rom_ready, overflow} !== 3'b100) begin
      n_fail++; $display("FAIL reload got rst=%b rdy=%b ovf=%b want 1/0/0", loader_rst, rom_ready, overflow); end
  endtask

  task automatic test_back_to_back();
    logic [1:0]  exp_mask;
    logic [16:0] exp_addr;
    for (int i = 0; i < 4; i++) begin
      ioctl_addr = 25'h10 + 25'(i);
      ioctl_data = 8'(8'hA0 + i);
      ioctl_wr   = 1'b1;
      tick();
      exp_mask = (i % 2 == 1) ? 2'b01 : 2'b10;
      exp_addr = (i < 2) ? 17'h8 : 17'h9;
      n_chk++; if ({prog_we, prog_addr, prog_mask, prog_data} !== {1'b1, exp_addr, exp_mask, 8'(8'hA0 + i)}) begin
        n_fail++; $display("FAIL b2b_%0d got we=%b addr=%h mask=%b data=%h want 1/%h/%b/%h",
                           i, prog_we, prog_addr, prog_mask, prog_data, exp_addr, exp_mask, 8'(8'hA0 + i)); end
    end
    ioctl_wr = 1'b0;
    tick();
    n_chk++; if (prog_we !== 1'b0) begin
      n_fail++; $display("FAIL b2b_end got we=%b want 0", prog_we); end
  endtask

  task automatic test_settle_abort();
    downloading = 1'b0;
    tick(); tick(); tick(); tick();
    downloading = 1'b1;
    tick();
    n_chk++; if ({loader_rst, rom_ready} !== 2'b10) begin
      n_fail++; $display("FAIL abort got rst=%b rdy=%b want 1/0", loader_rst, rom_ready); end
    wr_byte(25'h4, 8'hC3);
    n_chk++; if ({prog_we, prog_addr, prog_mask} !== {1'b1, 17'h2, 2'b10}) begin
      n_fail++; $display("FAIL abort_wr got we=%b addr=%h mask=%b want 1/2/10", prog_we, prog_addr, prog_mask); end
  endtask

  task automatic test_ignore_outside_load();
    int cyc;
    cyc = 0;
    downloading = 1'b0;
    for (int c = 1; c <= 40 && cyc == 0; c++) begin
      tick();
      if (rom_ready === 1'b1) cyc = c;
    end
    n_chk++; if (cyc != 17) begin
      n_fail++; $display("FAIL restart_settle got ready after %0d cycles want 17", cyc); end
    wr_byte(25'h20, 8'h99);
    n_chk++; if ({prog_we, prom_we, prog_data, prog_addr} !== {1'b0, 8'h00, 8'hC3, 17'h2}) begin
      n_fail++; $display("FAIL idle_rom got we=%b prom=%b data=%h addr=%h want 0/0/c3/2", prog_we, prom_we, prog_data, prog_addr); end
    wr_byte(ROM_END + 25'd4096, 8'h99);
    n_chk++; if ({prog_we, prom_we, overflow, loader_rst, rom_ready} !== {1'b0, 8'h00, 1'b0, 1'b0, 1'b1}) begin
      n_fail++; $display("FAIL idle_ovf got we=%b prom=%b ovf=%b rst=%b rdy=%b want 0/0/0/0/1",
                         prog_we, prom_we, overflow, loader_rst, rom_ready); end
  endtask

  task automatic test_rst_settle();
    int cyc;
    cyc = 0;
    downloading = 1'b1;
    tick();
    downloading = 1'b0;
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_chk++; if ({loader_rst, rom_ready, prog_mask, prog_addr} !== {1'b1, 1'b0, 2'b11, 17'h0}) begin
      n_fail++; $display("FAIL rst_settle got rst=%b rdy=%b mask=%b addr=%h want 1/0/11/0", loader_rst, rom_ready, prog_mask, prog_addr); end
    for (int c = 0; c < 20; c++) tick();
    n_chk++; if ({loader_rst, rom_ready} !== 2'b10) begin
      n_fail++; $display("FAIL idle_stays got rst=%b rdy=%b want 1/0", loader_rst, rom_ready); end
    // A write in LOAD colliding with rst must not strobe.
    downloading = 1'b1;
    tick();
    rst = 1'b1;
    wr_byte(25'h8, 8'h5A);
    rst = 1'b0;
    n_chk++; if ({prog_we, prog_data} !== {1'b0, 8'h00}) begin
      n_fail++; $display("FAIL rst_drop got we=%b data=%h want 0/00", prog_we, prog_data); end
    tick();
    wr_byte(25'h2, 8'h9A);
    n_chk++; if ({prog_we, prog_addr, prog_mask, prog_data} !== {1'b1, 17'h1, 2'b10, 8'h9A}) begin
      n_fail++; $display("FAIL post_rst_wr got we=%b addr=%h mask=%b data=%h want 1/1/10/9a", prog_we, prog_addr, prog_mask, prog_data); end
    downloading = 1'b0;
    for (int c = 1; c <= 40 && cyc == 0; c++) begin
      tick();
      if (rom_ready === 1'b1) cyc = c;
    end
    n_chk++; if (cyc != 17 || loader_rst !== 1'b0) begin
      n_fail++; $display("FAIL post_rst_done got ready after %0d cycles rst=%b want 17/0", cyc, loader_rst); end
  endtask

  initial begin
    test_reset();
    test_rom_lanes();
    test_prom();
    test_region_edges();
    test_settle();
    test_reload_clears();
    test_back_to_back();
    test_settle_abort();
    test_ignore_outside_load();
    test_rst_settle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
